// File: rtl/nv_nvdla_mcif_rd_pkg.sv
// Shared widths and field offsets for the MCIF read responder.
// Request carries a byte address and an atom count; responses carry data plus mask.
package nv_nvdla_mcif_rd_pkg;
    localparam int REQ_W     = 47;
    localparam int RSP_W     = 65;
    localparam int ADDR_LSB  = 0;
    localparam int ADDR_W    = 32;
    localparam int SIZE_LSB  = 32;
    localparam int SIZE_W    = 15;
    localparam int DATA_LSB  = 0;
    localparam int DATA_W    = 64;
    localparam int MASK_BIT  = 64;
    localparam int WADDR_W   = 29;
    localparam int WADDR_LSB = 3;

    typedef enum logic {
        IDLE,
        BURST
    } state_e;
endpackage

// File: rtl/nv_nvdla_mcif_rd_rsp_skid.sv
// Two-entry in-order response buffer between the SRAM read port and the client.
// Head entry is presented directly; count feeds the issue throttle.
module nv_nvdla_mcif_rd_rsp_skid
    import nv_nvdla_mcif_rd_pkg::*;
#(
    parameter int W = RSP_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         valid,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic         wptr;
    logic         rptr;
    logic         pop;

    assign valid   = (count != 2'd0);
    assign pop     = rd_en & valid;
    assign rd_data = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wptr   <= 1'b0;
            rptr   <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr_en) begin
                mem[wptr] <= wr_data;
                wptr      <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            count <= count + {1'b0, wr_en} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/nv_nvdla_mcif_rd_responder.sv
// MCIF-side read responder: expands atom-count requests into one-cycle SRAM
// reads, gated by client latency-FIFO credits, returning data in order.
module nv_nvdla_mcif_rd_responder
    import nv_nvdla_mcif_rd_pkg::*;
#(
    parameter int LAT_FIFO_DEPTH = 32
) (
    input  logic               nvdla_core_clk,
    input  logic               nvdla_core_rstn,
    input  logic               rd_req_valid,
    output logic               rd_req_ready,
    input  logic [REQ_W-1:0]   rd_req_pd,
    output logic               rd_rsp_valid,
    input  logic               rd_rsp_ready,
    output logic [RSP_W-1:0]   rd_rsp_pd,
    input  logic               cdt_lat_fifo_pop,
    output logic               mem_rd_en,
    output logic [WADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0]  mem_rd_data,
    output logic               busy,
    output logic               credit_err
);
    localparam int CW = $clog2(LAT_FIFO_DEPTH + 1);
    localparam logic [CW-1:0] CMAX = CW'(LAT_FIFO_DEPTH);

    state_e             state;
    logic [WADDR_W-1:0] waddr;
    logic [SIZE_W-1:0]  remain;
    logic               inflight;
    logic [CW-1:0]      credit;
    logic [1:0]         buf_count;
    logic [1:0]         occ;
    logic               rsp_pop;
    logic               issue;
    logic               req_hs;
    logic               unused_pd;

    assign unused_pd = ^rd_req_pd[WADDR_LSB-1:0];

    assign rsp_pop = rd_rsp_valid & rd_rsp_ready;
    // A head entry leaving this cycle frees its slot for the next issue.
    assign occ     = buf_count + {1'b0, inflight} - {1'b0, rsp_pop};
    assign issue   = (state == BURST) & (credit != '0) & (occ < 2'd2);
    assign req_hs  = rd_req_valid & rd_req_ready;

    assign rd_req_ready = (state == IDLE);
    assign mem_rd_en    = issue;
    assign mem_rd_addr  = waddr;
    assign busy         = (state == BURST) | inflight | (buf_count != 2'd0);

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state    <= IDLE;
            waddr    <= '0;
            remain   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            case (state)
                IDLE: begin
                    if (req_hs) begin
                        waddr  <= rd_req_pd[ADDR_LSB+WADDR_LSB +: WADDR_W];
                        remain <= rd_req_pd[SIZE_LSB +: SIZE_W];
                        state  <= BURST;
                    end
                end
                BURST: begin
                    if (issue) begin
                        waddr  <= waddr + 1'b1;
                        remain <= remain - 1'b1;
                        if (remain == '0) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            credit     <= CMAX;
            credit_err <= 1'b0;
        end else begin
            if (issue && !cdt_lat_fifo_pop) begin
                credit <= credit - 1'b1;
            end else if (!issue && cdt_lat_fifo_pop && credit != CMAX) begin
                credit <= credit + 1'b1;
            end
            if (cdt_lat_fifo_pop && credit == CMAX) begin
                credit_err <= 1'b1;
            end
        end
    end

    nv_nvdla_mcif_rd_rsp_skid #(
        .W(RSP_W)
    ) u_skid (
        .clk     (nvdla_core_clk),
        .rst_n   (nvdla_core_rstn),
        .wr_en   (inflight),
        .wr_data ({1'b1, mem_rd_data}),
        .rd_en   (rd_rsp_ready),
        .rd_data (rd_rsp_pd),
        .valid   (rd_rsp_valid),
        .count   (buf_count)
    );
endmodule
